// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - 8-digit multiplexed seven-segment scanner, frame-synchronous double buffer; optional SCAN_BLANK_EN
module seven_segment_scanner #(
    parameter int DIV   = 50000,
    parameter int BLANK = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [55:0] segs_in,
    input  logic        load,
    output logic        ready,
    output logic [6:0]  seg_out,
    output logic [7:0]  an_out,
    output logic        frame_tick
);

    localparam int            PW          = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST    = PW'(DIV - 1);
    localparam logic [PW-1:0] PRE_ONE     = PW'(1);
    localparam logic [PW-1:0] BLANK_START = PW'(DIV - BLANK);

`ifdef SCAN_BLANK_EN
    localparam bit BLANK_ENABLED = 1'b1;
`else
    localparam bit BLANK_ENABLED = 1'b0;
`endif

    logic [PW-1:0] prescaler;
    logic [2:0]    idx;
    logic [55:0]   active;
    logic [55:0]   pending;
    logic          pending_valid;

    logic [PW-1:0] prescaler_next;
    logic [2:0]    idx_next;
    logic [55:0]   active_next;
    logic          slot_wrap;
    logic          boundary;
    logic          accept;
    logic          blank_next;
    logic [6:0]    seg_sel;
    logic [7:0]    an_sel;

    assign ready = ~pending_valid;

    // Next scan position, frame boundary detection and the pattern to drive after this edge.
    always_comb begin
        slot_wrap      = 1'b0;
        boundary       = 1'b0;
        accept         = 1'b0;
        prescaler_next = prescaler;
        idx_next       = idx;
        active_next    = active;
        blank_next     = 1'b0;
        seg_sel        = 7'h7F;
        an_sel         = 8'hFF;

        slot_wrap = (prescaler == PRE_LAST);
        boundary  = slot_wrap && (idx == 3'd7);
        accept    = load && ~pending_valid;

        if (slot_wrap) begin
            prescaler_next = '0;
            idx_next       = idx + 3'd1;
        end else begin
            prescaler_next = prescaler + PRE_ONE;
        end

        // The digit-0 slot that opens on a boundary already shows the swapped-in frame.
        if (boundary && pending_valid) begin
            active_next = pending;
        end

        blank_next = BLANK_ENABLED && (prescaler_next >= BLANK_START);

        for (int k = 0; k < 8; k++) begin
            if (idx_next == 3'(k)) begin
                seg_sel = active_next[7*k +: 7];
            end
        end
        an_sel = ~(8'b1 << idx_next);

        if (blank_next) begin
            seg_sel = 7'h7F;
            an_sel  = 8'hFF;
        end
    end

    // Scan counters and the pending/active buffer pair; a load never lands in the frame it coincides with.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler     <= '0;
            idx           <= 3'd0;
            active        <= {56{1'b1}};
            pending       <= {56{1'b1}};
            pending_valid <= 1'b0;
        end else begin
            prescaler <= prescaler_next;
            idx       <= idx_next;
            active    <= active_next;
            if (accept) begin
                pending       <= segs_in;
                pending_valid <= 1'b1;
            end else if (boundary && pending_valid) begin
                pending_valid <= 1'b0;
            end
        end
    end

    // Registered display drive and end-of-frame pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_out    <= 7'h7F;
            an_out     <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            seg_out    <= seg_sel;
            an_out     <= an_sel;
            frame_tick <= boundary;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb/tb_seven_segment_scanner.sv - directed bench for seven_segment_scanner
module tb_seven_segment_scanner;

`ifdef SCAN_BLANK_EN
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam bit BLK   = 1'b1;
`else
    localparam int DIV   = 4;
    localparam int BLANK = 2;
    localparam bit BLK   = 1'b0;
`endif
    localparam int FRAME = 8 * DIV;

    // -1234567, active-low, bit6 = a ... bit0 = g
    localparam logic [6:0] D7 = 7'b1111110;
    localparam logic [6:0] D6 = 7'b1001111;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] D4 = 7'b0000110;
    localparam logic [6:0] D3 = 7'b1001100;
    localparam logic [6:0] D2 = 7'b0100100;
    localparam logic [6:0] D1 = 7'b0100000;
    localparam logic [6:0] D0 = 7'b0001111;

    logic        clk;
    logic        rst;
    logic [55:0] segs_in;
    logic        load;
    logic        ready;
    logic [6:0]  seg_out;
    logic [7:0]  an_out;
    logic        frame_tick;

    logic [55:0] p1;
    logic [55:0] p2;
    logic [55:0] p3;
    logic [55:0] blank_data;

    int total;
    int bad;
    int cyc;

    seven_segment_scanner #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst        (rst),
        .segs_in    (segs_in),
        .load       (load),
        .ready      (ready),
        .seg_out    (seg_out),
        .an_out     (an_out),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected drive for the slot position reached after edge number cyc since reset release.
    task automatic check_cycle(input logic [55:0] data, input logic exp_ready);
        int          i;
        int          p;
        logic [7:0]  ea;
        logic [6:0]  es;
        i  = (cyc / DIV) % 8;
        p  = cyc % DIV;
        ea = ~(8'b1 << i);
        es = data[7*i +: 7];
        if (BLK && p >= DIV - BLANK) begin
            ea = 8'hFF;
            es = 7'h7F;
        end
        chk("an", an_out, ea);
        chk("seg", seg_out, es);
        chk("tick", frame_tick, (cyc % FRAME) == 0);
        chk("ready", ready, exp_ready);
    endtask

    task automatic check_frame(input logic [55:0] data, input logic exp_ready);
        repeat (FRAME) begin
            check_cycle(data, exp_ready);
            tick();
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        cyc        = 0;
        p1         = {D7, D6, D5, D4, D3, D2, D1, D0};
        p2         = 56'h0;
        p3         = {D0, D1, D2, D3, D4, D5, D6, D7};
        blank_data = {56{1'b1}};
        rst        = 1'b1;
        load       = 1'b0;
        segs_in    = 56'h0;

        // reset state and first frames after release
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", an_out, 8'hFF);
        chk("rst_seg", seg_out, 7'h7F);
        chk("rst_ready", ready, 1'b1);
        chk("rst_tick", frame_tick, 1'b0);
        rst = 1'b0;
        cyc = 0;
        tick();
        chk("first_an", an_out, 8'hFE);
        chk("first_seg", seg_out, 7'h7F);
        repeat (FRAME - 1) begin
            check_cycle(blank_data, 1'b1);
            tick();
        end
        check_frame(blank_data, 1'b1);

        // load mid-frame, then a second load while not ready is dropped
        repeat (3 * DIV) begin
            check_cycle(blank_data, 1'b1);
            tick();
        end
        load    = 1'b1;
        segs_in = p1;
        tick();
        load    = 1'b0;
        chk("ready_after_load", ready, 1'b0);
        check_cycle(blank_data, 1'b0);
        load    = 1'b1;
        segs_in = p2;
        tick();
        load    = 1'b0;
        while (cyc % FRAME != 0) begin
            check_cycle(blank_data, 1'b0);
            tick();
        end
        check_frame(p1, 1'b1);

        // load on the boundary edge is held for one whole frame
        repeat (FRAME - 1) begin
            check_cycle(p1, 1'b1);
            tick();
        end
        check_cycle(p1, 1'b1);
        load    = 1'b1;
        segs_in = p3;
        tick();
        load    = 1'b0;
        chk("bnd_tick", frame_tick, 1'b1);
        check_frame(p1, 1'b0);
        check_frame(p3, 1'b1);

        // reset mid-slot of digit 3 with the pending buffer full
        check_cycle(p3, 1'b1);
        load    = 1'b1;
        segs_in = p1;
        tick();
        load    = 1'b0;
        repeat (3 * DIV) begin
            check_cycle(p3, 1'b0);
            tick();
        end
        chk("pre_rst_an", an_out, 8'hF7);
        chk("pre_rst_seg", seg_out, D4);
        #2;
        rst = 1'b1;
        #1;
        chk("async_an", an_out, 8'hFF);
        chk("async_seg", seg_out, 7'h7F);
        chk("async_ready", ready, 1'b1);
        chk("async_tick", frame_tick, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        tick();
        chk("rel_an", an_out, 8'hFE);
        chk("rel_seg", seg_out, 7'h7F);
        repeat (FRAME - 1) begin
            check_cycle(blank_data, 1'b1);
            tick();
        end
        check_frame(blank_data, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
